// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter and three-stage pipeline for RAM port 1.
// Stage A arbitrates, B drives the RAM, C returns a tagged response.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wenable,
  input  logic [31:0]           ram_rdata
);

  logic                  last_q;

  logic                  b_valid_q;
  logic                  b_id_q;
  logic [ADDR_WIDTH-1:0] b_addr_q;
  logic [31:0]           b_wdata_q;
  logic [3:0]            b_wstrb_q;

  logic                  c_valid_q;
  logic                  c_id_q;
  logic [31:0]           c_rdata_q;

  logic                  xfer;
  logic                  win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [31:0]           win_wdata;
  logic [3:0]            win_wstrb;

  // On a tie the master that did not win last time gets the grant.
  always_comb begin
    m0_ready  = m0_req && (!m1_req || last_q);
    m1_ready  = m1_req && (!m0_req || !last_q);
    xfer      = m0_ready || m1_ready;
    win_id    = m1_ready;
    win_addr  = m1_ready ? m1_addr  : m0_addr;
    win_wdata = m1_ready ? m1_wdata : m0_wdata;
    win_wstrb = m1_ready ? m1_wstrb : m0_wstrb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      b_valid_q <= 1'b0;
      b_id_q    <= 1'b0;
      b_addr_q  <= '0;
      b_wdata_q <= 32'h0;
      b_wstrb_q <= 4'h0;
      c_valid_q <= 1'b0;
      c_id_q    <= 1'b0;
      c_rdata_q <= 32'h0;
    end else begin
      if (xfer) begin
        last_q <= win_id;
      end
      b_valid_q <= xfer;
      b_id_q    <= win_id;
      b_addr_q  <= win_addr;
      b_wdata_q <= win_wdata;
      b_wstrb_q <= win_wstrb;
      c_valid_q <= b_valid_q;
      c_id_q    <= b_id_q;
      c_rdata_q <= (b_wstrb_q == 4'h0) ? ram_rdata : 32'h0;
    end
  end

  // rst_n gates the write strobe directly so a command caught by reset never commits.
  always_comb begin
    ram_addr    = b_addr_q;
    ram_wdata   = b_wdata_q;
    ram_wenable = (b_valid_q && rst_n) ? b_wstrb_q : 4'h0;
    m0_rvalid   = c_valid_q && !c_id_q;
    m1_rvalid   = c_valid_q && c_id_q;
    m0_rdata    = c_rdata_q;
    m1_rdata    = c_rdata_q;
  end

endmodule
